// File: rtl/ssd1306_spi_rx.sv
// ssd1306_spi_rx
//   Receive side of the SSD1306 4-wire write-only SPI link. Samples the OLED
//   pins, reassembles bytes, decodes the command set into display state and
//   turns data bytes into GDDRAM writes with SSD1306 address auto-increment.
//
//   Optional feature macro: SSD1306_RX_CS_EN adds oled_cs_n framing.
//
// Ports
//   clk_50M, rst_n          system clock, async active-low reset
//   oled_sclk/sdin/dc/res   SPI pins (mode 0, MSB first), dc=1 data, res low = clear
//   oled_cs_n               chip select, only with SSD1306_RX_CS_EN
//   ram_we/addr/wdata       one-cycle GDDRAM write, addr = page*COLS + col
//   cmd_valid/cmd_byte      completed command pulse / its opcode (held)
//   disp_on, contrast, invert, mem_mode   decoded display state
//   err_pulse               unknown opcode or aborted parameter sequence
module ssd1306_spi_rx #(
  parameter int COLS       = 128,
  parameter int PAGES      = 8,
  parameter int RAM_ADDR_W = 10
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  input  logic                  oled_sclk,
  input  logic                  oled_sdin,
  input  logic                  oled_dc,
  input  logic                  oled_res,
`ifdef SSD1306_RX_CS_EN
  input  logic                  oled_cs_n,
`endif
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_byte,
  output logic                  disp_on,
  output logic [7:0]            contrast,
  output logic                  invert,
  output logic [1:0]            mem_mode,
  output logic                  err_pulse
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  // ---------------- input conditioning ----------------
  logic [1:0] sclk_q, sdin_q, dc_q, res_q, cs_q;
  logic       sclk_d, cs_d;
  logic       rise, cs_rise;

`ifdef SSD1306_RX_CS_EN
  logic cs_pin;
  assign cs_pin = oled_cs_n;
`else
  logic cs_pin;
  assign cs_pin = 1'b0;
`endif

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      sdin_q <= '0;
      dc_q   <= '0;
      res_q  <= '0;   // hold the decoder clear until res is seen high
      cs_q   <= '1;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[0], oled_sclk};
      sdin_q <= {sdin_q[0], oled_sdin};
      dc_q   <= {dc_q[0],   oled_dc};
      res_q  <= {res_q[0],  oled_res};
      cs_q   <= {cs_q[0],   cs_pin};
      sclk_d <= sclk_q[1];
      cs_d   <= cs_q[1];
    end
  end

  // Edges while deselected are ignored; without the feature cs_q stays low.
  assign rise    = sclk_q[1] & ~sclk_d & ~cs_q[1];
  assign cs_rise = cs_q[1] & ~cs_d;

  // ---------------- bit capture ----------------
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic       byte_vld, byte_dc;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      bit_cnt  <= '0;
      byte_vld <= 1'b0;
      byte_dc  <= 1'b0;
    end else if (!res_q[1]) begin
      bit_cnt  <= '0;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      if (cs_rise) begin
        bit_cnt <= '0;   // partial byte dropped silently
      end else if (rise) begin
        sh      <= {sh[6:0], sdin_q[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_dc  <= dc_q[1];
        end
      end
    end
  end

  // ---------------- decoder ----------------
  typedef enum logic {IDLE, PARAM} st_t;

  typedef struct packed {
    st_t                   state;
    logic [1:0]            n;
    logic [7:0]            op;
    logic [7:0]            p0;
    logic [CW-1:0]         col, col_s, col_e;
    logic [PW-1:0]         page, page_s, page_e;
    logic [1:0]            mem_mode;
    logic [7:0]            contrast;
    logic                  disp_on, invert;
    logic                  cmd_valid;
    logic [7:0]            cmd_byte;
    logic                  err;
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [7:0]            wdata;
  } regs_t;

  localparam regs_t RST = '{state: IDLE, n: 2'd0, op: 8'h00, p0: 8'h00,
                            col: '0, col_s: '0, col_e: CW'(COLS-1),
                            page: '0, page_s: '0, page_e: PW'(PAGES-1),
                            mem_mode: 2'b10, contrast: 8'h7F,
                            disp_on: 1'b0, invert: 1'b0, cmd_valid: 1'b0,
                            cmd_byte: 8'h00, err: 1'b0, we: 1'b0,
                            addr: '0, wdata: 8'h00};

  regs_t r, nx;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) r <= RST;
    else        r <= nx;
  end

  always_comb begin
    nx           = r;
    nx.cmd_valid = 1'b0;
    nx.err       = 1'b0;
    nx.we        = 1'b0;
    if (!res_q[1]) begin
      nx = RST;
    end else if (byte_vld) begin
      if (byte_dc) begin
        if (r.state == PARAM) begin   // data cuts a parameter sequence short
          nx.err   = 1'b1;
          nx.state = IDLE;
          nx.n     = 2'd0;
        end
        nx.we    = 1'b1;
        nx.addr  = RAM_ADDR_W'(r.page) * RAM_ADDR_W'(COLS) + RAM_ADDR_W'(r.col);
        nx.wdata = sh;
        unique case (r.mem_mode)
          2'b00: begin
            if (r.col == r.col_e) begin
              nx.col  = r.col_s;
              nx.page = (r.page == r.page_e) ? r.page_s : r.page + PW'(1);
            end else nx.col = r.col + CW'(1);
          end
          2'b01: begin
            if (r.page == r.page_e) begin
              nx.page = r.page_s;
              nx.col  = (r.col == r.col_e) ? r.col_s : r.col + CW'(1);
            end else nx.page = r.page + PW'(1);
          end
          default: nx.col = (r.col == CW'(COLS-1)) ? '0 : r.col + CW'(1);
        endcase
      end else if (r.state == PARAM) begin
        nx.n = r.n - 2'd1;
        if (r.n == 2'd2) nx.p0 = sh;
        if (r.n == 2'd1) begin
          nx.state     = IDLE;
          nx.cmd_valid = 1'b1;
          nx.cmd_byte  = r.op;
          case (r.op)
            8'h81: nx.contrast = sh;
            8'h20: nx.mem_mode = sh[1:0];
            8'h21: begin
              nx.col_s = r.p0[CW-1:0];
              nx.col_e = sh[CW-1:0];
              nx.col   = r.p0[CW-1:0];
            end
            8'h22: begin
              nx.page_s = r.p0[PW-1:0];
              nx.page_e = sh[PW-1:0];
              nx.page   = r.p0[PW-1:0];
            end
            default: ;
          endcase
        end
      end else begin
        nx.op = sh;
        casez (sh)
          8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: begin
            nx.state = PARAM;
            nx.n     = 2'd1;
          end
          8'h21, 8'h22: begin
            nx.state = PARAM;
            nx.n     = 2'd2;
          end
          8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'hA4, 8'hA5, 8'hA0, 8'hA1,
          8'hC0, 8'hC8, 8'b01??????, 8'b0000????, 8'b00010???, 8'b10110???: begin
            nx.cmd_valid = 1'b1;
            nx.cmd_byte  = sh;
            if (sh == 8'hAE || sh == 8'hAF) nx.disp_on = sh[0];
            if (sh == 8'hA6 || sh == 8'hA7) nx.invert  = sh[0];
            if (sh[7:4] == 4'h0) nx.col[3:0] = sh[3:0];
            if (sh[7:3] == 5'b00010) nx.col[CW-1:4] = sh[CW-5:0];
            if (sh[7:3] == 5'b10110) nx.page = sh[PW-1:0];
          end
          default: nx.err = 1'b1;
        endcase
      end
    end
  end

  assign ram_we    = r.we;
  assign ram_addr  = r.addr;
  assign ram_wdata = r.wdata;
  assign cmd_valid = r.cmd_valid;
  assign cmd_byte  = r.cmd_byte;
  assign disp_on   = r.disp_on;
  assign contrast  = r.contrast;
  assign invert    = r.invert;
  assign mem_mode  = r.mem_mode;
  assign err_pulse = r.err;

endmodule

// File: doc/ssd1306_spi_rx.md
# ssd1306_spi_rx

Receiving end of the SSD1306 4-wire write-only SPI link. It samples oled_sclk / oled_sdin / oled_dc / oled_res as driven by our OLED init sequencer and reassembles bytes. It decodes the SSD1306 command set into display state registers and turns data bytes into GDDRAM writes with SSD1306 address auto-increment. It is used as an on-chip loopback display model for bring-up and as the DUT-side checker in sequencer benches.

## Interface
Parameters:
- COLS, 128, display columns; column pointer width is 7.
- PAGES, 8, display pages; page pointer width is 3.
- RAM_ADDR_W, 10, GDDRAM byte address width; must equal log2(COLS*PAGES).

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- oled_sclk  in  1  SPI clock, mode 0; asynchronous to clk_50M.
- oled_sdin  in  1  SPI data, MSB first.
- oled_dc  in  1  0 = command byte, 1 = data byte.
- oled_res  in  1  display reset, active-low.
- oled_cs_n  in  1  chip select, active-low; present only with SSD1306_RX_CS_EN.
- ram_we  out  1  one-cycle GDDRAM write strobe.
- ram_addr  out  RAM_ADDR_W  write address, page*COLS + col.
- ram_wdata  out  8  write data.
- cmd_valid  out  1  one-cycle pulse when a command, including all its parameters, has completed.
- cmd_byte  out  8  opcode of the completed command; held until the next cmd_valid.
- disp_on  out  1  set by 0xAF, cleared by 0xAE.
- contrast  out  8  parameter of 0x81.
- invert  out  1  set by 0xA7, cleared by 0xA6.
- mem_mode  out  2  parameter bits [1:0] of 0x20.
- err_pulse  out  1  one-cycle pulse on an unknown opcode or an aborted parameter sequence.

## Operation
- Input conditioning:
  - oled_sclk, oled_sdin, oled_dc, oled_res and oled_cs_n each pass through a 2-FF synchronizer.
  - An edge register on synchronized sclk detects the rising edge.
- Bit capture:
  - On each sclk rising edge, shift sdin into an 8-bit register, MSB first, and increment a 3-bit bit counter.
  - On the 8th edge (counter wraps 7->0), the byte is complete and dc is sampled at that same edge.
- Decoder FSM states:
  - IDLE: expecting an opcode.
  - PARAM: n parameters remain; n is 1 or 2, held in a 2-bit counter.
- Command byte in IDLE:
  - 1-parameter opcodes (enter PARAM, n=1): 0x81, 0x20, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x8D.
  - 2-parameter opcodes (enter PARAM, n=2): 0x21 (col start/end), 0x22 (page start/end).
  - 0-parameter opcodes (cmd_valid next cycle, stay IDLE): 0xAE/AF, 0xA6/A7, 0xA4/A5, 0xA0/A1, 0xC0/C8, 0x40-0x7F.
  - 0x00-0x0F: col[3:0] <= byte[3:0], 0-parameter.
  - 0x10-0x17: col[6:4] <= byte[2:0], 0-parameter.
  - 0xB0-0xB7: page <= byte[2:0], 0-parameter.
  - Any other value: err_pulse, treated as 0-parameter, cmd_valid not asserted.
- Command byte in PARAM:
  - Store the parameter and decrement n.
  - When n reaches 0: apply the side effect, pulse cmd_valid, return to IDLE.
  - 0x21 sets col_start/col_end and col <= col_start.
  - 0x22 sets page_start/page_end and page <= page_start.
  - Parameters of the other 1-parameter opcodes are consumed and discarded, except 0x81 (contrast) and 0x20 (mem_mode).
- Data byte (dc=1):
  - Arriving in PARAM: first abort (err_pulse, return to IDLE, no cmd_valid), then process the byte as data.
  - Processing: ram_we with the current address, then advance the pointers by mem_mode.
- Pointer advance by mem_mode:
  - 00 horizontal: col++. At col_end, col <= col_start and page++; page wraps at page_end to page_start.
  - 01 vertical: page++. At page_end, page <= page_start and col++; col wraps at col_end to col_start.
  - 10 or 11 page: col++; col wraps at COLS-1 to 0; page unchanged.

## Timing
- Reset values (rst_n low, or synchronized oled_res low):
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - cmd_valid=0, cmd_byte=0x00, err_pulse=0.
  - disp_on=0, contrast=0x7F, invert=0, mem_mode=2'b10.
  - col=0, page=0, col range 0..127, page range 0..7.
  - Bit counter 0, FSM in IDLE.
- oled_res low is a synchronous clear after synchronization. A byte completing in the same cycle that res is seen low is discarded.
- Latency, pin edge to detected rising edge: 3 clk_50M cycles.
- Latency, byte-complete detection to output:
  - ram_we or cmd_valid or err_pulse is asserted exactly 1 cycle later.
  - Pointers and state registers update in that same cycle, visible the following cycle.
- Minimum sclk high and low time: 4 clk_50M cycles each (sclk <= 6.25 MHz). Faster clocks are unsupported.
- Every strobe is a single cycle. Abort and data write are pulsed simultaneously in the same cycle.

## Configuration
- SSD1306_RX_CS_EN defined:
  - The oled_cs_n port exists.
  - Edges are ignored while cs_n is high.
  - A cs_n rising edge clears the bit counter, so a partial byte is dropped without error. FSM state is kept.
- SSD1306_RX_CS_EN undefined:
  - No oled_cs_n port.
  - Framing is continuous from the deassertion of oled_res or rst_n.

## Test plan
- Bytes 0xAF (dc=0), then 0x81, 0x3C -> disp_on=1 with cmd_valid and cmd_byte=0xAF. Then contrast=0x3C with a single cmd_valid (cmd_byte=0x81) after the 2nd byte.
- 0x20,0x00; 0x21,0x7E,0x7F; 0x22,0x06,0x07; then 4 data bytes 0xA1-0xA4 -> ram_addr sequence 894, 895, 1022, 1023, then wraps to col 126 page 6.
- Default page mode, 0xB3, 0x05, 0x12, then data 0x55 -> ram_we with ram_addr = 3*128 + 0x25 = 421, ram_wdata = 0x55.
- 0x81 then data 0x99 -> err_pulse and ram_we in the same cycle, contrast unchanged at 0x7F, FSM back in IDLE. Opcode 0xFF -> err_pulse only.
- 3 bits shifted, then oled_res low for 10 cycles, then 0xA7 -> the partial byte is lost, invert=1 with no err_pulse. With SSD1306_RX_CS_EN, repeat using a cs_n pulse instead of res and check the same result.
